// File: rtl/clock_pkg.sv
// Shared definitions for the century clock: adjust-field selects, BCD limits
// and the leap-year decode.
package clock_pkg;

    typedef enum logic [1:0] {
        SEL_DAY   = 2'd0,
        SEL_MONTH = 2'd1,
        SEL_YEAR  = 2'd2,
        SEL_NONE  = 2'd3
    } sel_e;

    typedef logic [7:0] bcd8_t;

    localparam bcd8_t BCD_12 = 8'h12;
    localparam bcd8_t BCD_99 = 8'h99;
    localparam bcd8_t BCD_31 = 8'h31;
    localparam bcd8_t BCD_30 = 8'h30;
    localparam bcd8_t BCD_29 = 8'h29;
    localparam bcd8_t BCD_28 = 8'h28;

    // YY mod 4 == 0 decoded directly on BCD digits: even tens take 0/4/8, odd tens take 2/6.
    function automatic logic is_leap(input logic ten_lsb, input logic [3:0] unit);
        if (ten_lsb)
            return (unit == 4'd2) || (unit == 4'd6);
        else
            return (unit == 4'd0) || (unit == 4'd4) || (unit == 4'd8);
    endfunction

endpackage

// File: rtl/days_in_month.sv
// Month length decode: BCD month plus leap flag to BCD maximum day.
module days_in_month
    import clock_pkg::*;
#(
    parameter int UNIT_W    = 4,
    parameter int DAY_TEN_W = 2
) (
    input  logic                 month_ten,
    input  logic [UNIT_W-1:0]    month_unit,
    input  logic                 leap,
    output logic [DAY_TEN_W-1:0] maxd_ten,
    output logic [UNIT_W-1:0]    maxd_unit
);

    always_comb begin
        maxd_ten  = BCD_31[UNIT_W +: DAY_TEN_W];
        maxd_unit = BCD_31[UNIT_W-1:0];
        case ({month_ten, month_unit})
            5'h04, 5'h06, 5'h09, 5'h11: begin
                maxd_ten  = BCD_30[UNIT_W +: DAY_TEN_W];
                maxd_unit = BCD_30[UNIT_W-1:0];
            end
            5'h02: begin
                if (leap) begin
                    maxd_ten  = BCD_29[UNIT_W +: DAY_TEN_W];
                    maxd_unit = BCD_29[UNIT_W-1:0];
                end else begin
                    maxd_ten  = BCD_28[UNIT_W +: DAY_TEN_W];
                    maxd_unit = BCD_28[UNIT_W-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/count_date.sv
// Day/month/year BCD calendar stage: one-day advance per en_d strobe, manual
// per-field adjust when idle, century strobe at 31/12/99 rollover.
module count_date
    import clock_pkg::*;
#(
    parameter int UNIT_W     = 4,
    parameter int DAY_TEN_W  = 2,
    parameter int YEAR_TEN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_d,
    input  logic                  up,
    input  logic                  down,
    input  logic [1:0]            sel,
    output logic [UNIT_W-1:0]     day_unit,
    output logic [DAY_TEN_W-1:0]  day_ten,
    output logic [UNIT_W-1:0]     month_unit,
    output logic                  month_ten,
    output logic [UNIT_W-1:0]     year_unit,
    output logic [YEAR_TEN_W-1:0] year_ten,
    output logic                  pulse_cen
);

    localparam logic [UNIT_W-1:0]     U0  = '0;
    localparam logic [UNIT_W-1:0]     U1  = UNIT_W'(1);
    localparam logic [UNIT_W-1:0]     U2  = UNIT_W'(2);
    localparam logic [UNIT_W-1:0]     U9  = UNIT_W'(9);
    localparam logic [DAY_TEN_W-1:0]  DT0 = '0;
    localparam logic [DAY_TEN_W-1:0]  DT1 = DAY_TEN_W'(1);
    localparam logic [YEAR_TEN_W-1:0] YT0 = '0;
    localparam logic [YEAR_TEN_W-1:0] YT1 = YEAR_TEN_W'(1);
    localparam logic [YEAR_TEN_W-1:0] YT9 = YEAR_TEN_W'(9);

    sel_e                  sel_s;
    logic                  adj_any;
    logic                  leap_cur, leap_nxt;
    logic [DAY_TEN_W-1:0]  maxd_ten_c, maxd_ten_n;
    logic [UNIT_W-1:0]     maxd_unit_c, maxd_unit_n;
    logic                  day_wrap, day_is_01, month_is_12, year_is_99, day_is_31;

    logic [DAY_TEN_W-1:0]  day_ten_d, day_ten_inc, day_ten_dec;
    logic [UNIT_W-1:0]     day_unit_d, day_unit_inc, day_unit_dec;
    logic                  month_ten_d, month_ten_inc, month_ten_dec;
    logic [UNIT_W-1:0]     month_unit_d, month_unit_inc, month_unit_dec;
    logic [YEAR_TEN_W-1:0] year_ten_d, year_ten_inc, year_ten_dec;
    logic [UNIT_W-1:0]     year_unit_d, year_unit_inc, year_unit_dec;

    assign sel_s   = sel_e'(sel);
    assign adj_any = up ^ down;

    assign leap_cur = is_leap(year_ten[0], year_unit);
    assign leap_nxt = is_leap(year_ten_d[0], year_unit_d);

    days_in_month #(.UNIT_W(UNIT_W), .DAY_TEN_W(DAY_TEN_W)) u_dim_cur (
        .month_ten  (month_ten),
        .month_unit (month_unit),
        .leap       (leap_cur),
        .maxd_ten   (maxd_ten_c),
        .maxd_unit  (maxd_unit_c)
    );

    // Length of the month the date is about to land in, used for the day clamp.
    days_in_month #(.UNIT_W(UNIT_W), .DAY_TEN_W(DAY_TEN_W)) u_dim_nxt (
        .month_ten  (month_ten_d),
        .month_unit (month_unit_d),
        .leap       (leap_nxt),
        .maxd_ten   (maxd_ten_n),
        .maxd_unit  (maxd_unit_n)
    );

    assign day_wrap    = ({day_ten, day_unit} == {maxd_ten_c, maxd_unit_c});
    assign day_is_01   = (day_ten == DT0) && (day_unit == U1);
    assign day_is_31   = ({day_ten, day_unit} == BCD_31[DAY_TEN_W+UNIT_W-1:0]);
    assign month_is_12 = ({month_ten, month_unit} == BCD_12[UNIT_W:0]);
    assign year_is_99  = ({year_ten, year_unit} == BCD_99[YEAR_TEN_W+UNIT_W-1:0]);

    assign pulse_cen = en_d & day_is_31 & month_is_12 & year_is_99;

    // Single-step BCD candidates for every field; the muxes below pick one.
    always_comb begin
        day_ten_inc  = (day_unit == U9) ? day_ten + DT1 : day_ten;
        day_unit_inc = (day_unit == U9) ? U0 : day_unit + U1;
        day_ten_dec  = (day_unit == U0) ? day_ten - DT1 : day_ten;
        day_unit_dec = (day_unit == U0) ? U9 : day_unit - U1;

        month_ten_inc  = month_ten;
        month_unit_inc = month_unit + U1;
        if (month_is_12) begin
            month_ten_inc  = 1'b0;
            month_unit_inc = U1;
        end else if (month_unit == U9) begin
            month_ten_inc  = 1'b1;
            month_unit_inc = U0;
        end

        month_ten_dec  = month_ten;
        month_unit_dec = month_unit - U1;
        if (!month_ten && month_unit == U1) begin
            month_ten_dec  = 1'b1;
            month_unit_dec = U2;
        end else if (month_unit == U0) begin
            month_ten_dec  = 1'b0;
            month_unit_dec = U9;
        end

        year_ten_inc  = year_ten;
        year_unit_inc = year_unit + U1;
        if (year_unit == U9) begin
            year_ten_inc  = (year_ten == YT9) ? YT0 : year_ten + YT1;
            year_unit_inc = U0;
        end

        year_ten_dec  = year_ten;
        year_unit_dec = year_unit - U1;
        if (year_unit == U0) begin
            year_ten_dec  = (year_ten == YT0) ? YT9 : year_ten - YT1;
            year_unit_dec = U9;
        end
    end

    always_comb begin
        month_ten_d  = month_ten;
        month_unit_d = month_unit;
        year_ten_d   = year_ten;
        year_unit_d  = year_unit;
        if (en_d) begin
            if (day_wrap) begin
                month_ten_d  = month_ten_inc;
                month_unit_d = month_unit_inc;
                if (month_is_12) begin
                    year_ten_d  = year_ten_inc;
                    year_unit_d = year_unit_inc;
                end
            end
        end else if (adj_any) begin
            if (sel_s == SEL_MONTH) begin
                month_ten_d  = up ? month_ten_inc  : month_ten_dec;
                month_unit_d = up ? month_unit_inc : month_unit_dec;
            end else if (sel_s == SEL_YEAR) begin
                year_ten_d  = up ? year_ten_inc  : year_ten_dec;
                year_unit_d = up ? year_unit_inc : year_unit_dec;
            end
        end
    end

    always_comb begin
        day_ten_d  = day_ten;
        day_unit_d = day_unit;
        if (en_d) begin
            if (day_wrap) begin
                day_ten_d  = DT0;
                day_unit_d = U1;
            end else begin
                day_ten_d  = day_ten_inc;
                day_unit_d = day_unit_inc;
            end
        end else if (adj_any) begin
            if (sel_s == SEL_DAY) begin
                if (up) begin
                    day_ten_d  = day_wrap ? DT0 : day_ten_inc;
                    day_unit_d = day_wrap ? U1  : day_unit_inc;
                end else begin
                    day_ten_d  = day_is_01 ? maxd_ten_c  : day_ten_dec;
                    day_unit_d = day_is_01 ? maxd_unit_c : day_unit_dec;
                end
            end else if ({day_ten, day_unit} > {maxd_ten_n, maxd_unit_n}) begin
                day_ten_d  = maxd_ten_n;
                day_unit_d = maxd_unit_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_ten    <= DT0;
            day_unit   <= U1;
            month_ten  <= 1'b0;
            month_unit <= U1;
            year_ten   <= YT0;
            year_unit  <= U0;
        end else begin
            day_ten    <= day_ten_d;
            day_unit   <= day_unit_d;
            month_ten  <= month_ten_d;
            month_unit <= month_unit_d;
            year_ten   <= year_ten_d;
            year_unit  <= year_unit_d;
        end
    end

endmodule

// File: tb/tb_count_date.sv
// Self-checking bench for count_date: directed calendar scenarios plus random
// stimulus against an integer day/month/year reference model.
module tb_count_date;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_d = 1'b0, up = 1'b0, down = 1'b0;
    logic [1:0] sel = 2'd3;
    logic [3:0] day_unit, month_unit, year_unit, year_ten;
    logic [1:0] day_ten;
    logic       month_ten, pulse_cen;

    int n_tests = 0;
    int n_fail  = 0;
    int md = 1, mm = 1, my = 0;

    always #5 clk = ~clk;

    count_date #(.UNIT_W(4), .DAY_TEN_W(2), .YEAR_TEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_d       (en_d),
        .up         (up),
        .down       (down),
        .sel        (sel),
        .day_unit   (day_unit),
        .day_ten    (day_ten),
        .month_unit (month_unit),
        .month_ten  (month_ten),
        .year_unit  (year_unit),
        .year_ten   (year_ten),
        .pulse_cen  (pulse_cen)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int maxd(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [23:0] bcd_date(int d, int m, int y);
        return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10), 4'(y / 10), 4'(y % 10)};
    endfunction

    function automatic logic [23:0] dut_date();
        return {2'b00, day_ten, day_unit, 3'b000, month_ten, month_unit, year_ten, year_unit};
    endfunction

    task automatic model_step(input logic e, input logic u, input logic dn, input logic [1:0] s);
        int lim;
        if (e) begin
            if (md < maxd(mm, my)) md++;
            else begin
                md = 1;
                if (mm < 12) mm++;
                else begin
                    mm = 1;
                    my = (my + 1) % 100;
                end
            end
        end else if (u != dn) begin
            lim = maxd(mm, my);
            case (s)
                2'd0: md = u ? ((md == lim) ? 1 : md + 1) : ((md == 1) ? lim : md - 1);
                2'd1: mm = u ? (mm % 12 + 1) : ((mm == 1) ? 12 : mm - 1);
                2'd2: my = u ? (my + 1) % 100 : (my + 99) % 100;
                default: ;
            endcase
            if (md > maxd(mm, my)) md = maxd(mm, my);
        end
    endtask

    // One clock of stimulus: pulse_cen checked mid-cycle, date checked after the edge.
    task automatic cycle(input logic e, input logic u, input logic dn, input logic [1:0] s);
        logic exp_p;
        en_d = e; up = u; down = dn; sel = s;
        @(negedge clk);
        exp_p = e && md == 31 && mm == 12 && my == 99;
        n_tests++;
        if (pulse_cen !== exp_p) begin
            n_fail++;
            $display("FAIL pulse_cen: got %b expected %b at %h", pulse_cen, exp_p, bcd_date(md, mm, my));
        end
        @(posedge clk);
        #1;
        model_step(e, u, dn, s);
        n_tests++;
        if (dut_date() !== bcd_date(md, mm, my)) begin
            n_fail++;
            $display("FAIL date: got %h expected %h (en=%b up=%b dn=%b sel=%0d)",
                     dut_date(), bcd_date(md, mm, my), e, u, dn, s);
        end
        en_d = 1'b0; up = 1'b0; down = 1'b0; sel = 2'd3;
    endtask

    task automatic set_date(input int d, input int m, input int y);
        for (int k = 0; k < 120 && my != y; k++) cycle(1'b0, y > my, y < my, 2'd2);
        for (int k = 0; k < 20 && mm != m; k++) cycle(1'b0, m > mm, m < mm, 2'd1);
        for (int k = 0; k < 40 && md != d; k++) cycle(1'b0, d > md, d < md, 2'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        md = 1; mm = 1; my = 0;
        #1;
        n_tests++;
        if (dut_date() !== 24'h010100) begin
            n_fail++; $display("FAIL reset_date: got %h expected 010100", dut_date());
        end
        n_tests++;
        if (pulse_cen !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulse: got %b expected 0", pulse_cen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'd3);
        set_date(31, 12, 99);
        en_d = 1'b1;
        #1;
        n_tests++;
        if (pulse_cen !== 1'b1) begin
            n_fail++; $display("FAIL mid_pulse_pre: got %b expected 1", pulse_cen);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (pulse_cen !== 1'b0) begin
            n_fail++; $display("FAIL mid_pulse_rst: got %b expected 0", pulse_cen);
        end
        n_tests++;
        if (dut_date() !== 24'h010100) begin
            n_fail++; $display("FAIL mid_rst_date: got %h expected 010100", dut_date());
        end
        en_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        md = 1; mm = 1; my = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_month_ends();
        set_date(28, 2, 23);
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h010323) begin
            n_fail++; $display("FAIL feb_nonleap: got %h expected 010323", dut_date());
        end
        set_date(28, 2, 24);
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h290224) begin
            n_fail++; $display("FAIL feb_leap29: got %h expected 290224", dut_date());
        end
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h010324) begin
            n_fail++; $display("FAIL feb_leap_end: got %h expected 010324", dut_date());
        end
        set_date(30, 4, 24);
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h010524) begin
            n_fail++; $display("FAIL apr_end: got %h expected 010524", dut_date());
        end
        set_date(9, 1, 5);
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h100105) begin
            n_fail++; $display("FAIL day_carry: got %h expected 100105", dut_date());
        end
    endtask

    task automatic test_century();
        set_date(31, 12, 98);
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h010199) begin
            n_fail++; $display("FAIL year_98_99: got %h expected 010199", dut_date());
        end
        set_date(31, 12, 99);
        en_d = 1'b1;
        #1;
        n_tests++;
        if (pulse_cen !== 1'b1) begin
            n_fail++; $display("FAIL cen_pulse: got %b expected 1", pulse_cen);
        end
        cycle(1'b1, 1'b0, 1'b0, 2'd3);
        #1;
        n_tests++;
        if (dut_date() !== 24'h010100 || pulse_cen !== 1'b0) begin
            n_fail++; $display("FAIL cen_roll: got %h/%b expected 010100/0", dut_date(), pulse_cen);
        end
        set_date(31, 12, 99);
        cycle(1'b0, 1'b1, 1'b0, 2'd2);
        n_tests++;
        if (dut_date() !== 24'h311200) begin
            n_fail++; $display("FAIL adj_99_00: got %h expected 311200", dut_date());
        end
    endtask

    task automatic test_adjust_clamp();
        set_date(31, 1, 23);
        cycle(1'b0, 1'b1, 1'b0, 2'd1);
        n_tests++;
        if (dut_date() !== 24'h280223) begin
            n_fail++; $display("FAIL clamp_month: got %h expected 280223", dut_date());
        end
        set_date(29, 2, 24);
        cycle(1'b0, 1'b0, 1'b1, 2'd2);
        n_tests++;
        if (dut_date() !== 24'h280223) begin
            n_fail++; $display("FAIL clamp_year: got %h expected 280223", dut_date());
        end
        set_date(1, 3, 24);
        cycle(1'b0, 1'b0, 1'b1, 2'd0);
        n_tests++;
        if (dut_date() !== 24'h310324) begin
            n_fail++; $display("FAIL day_down_wrap: got %h expected 310324", dut_date());
        end
    endtask

    task automatic test_wraps_holds();
        set_date(15, 12, 40);
        cycle(1'b0, 1'b1, 1'b0, 2'd1);
        n_tests++;
        if (dut_date() !== 24'h150140) begin
            n_fail++; $display("FAIL month_wrap: got %h expected 150140", dut_date());
        end
        set_date(10, 5, 0);
        cycle(1'b0, 1'b0, 1'b1, 2'd2);
        n_tests++;
        if (dut_date() !== 24'h100599) begin
            n_fail++; $display("FAIL year_down_wrap: got %h expected 100599", dut_date());
        end
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        n_tests++;
        if (dut_date() !== 24'h100599) begin
            n_fail++; $display("FAIL hold_both: got %h expected 100599", dut_date());
        end
        cycle(1'b0, 1'b1, 1'b0, 2'd3);
        n_tests++;
        if (dut_date() !== 24'h100599) begin
            n_fail++; $display("FAIL hold_sel3: got %h expected 100599", dut_date());
        end
    endtask

    task automatic test_priority();
        set_date(15, 6, 30);
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        n_tests++;
        if (dut_date() !== 24'h160630) begin
            n_fail++; $display("FAIL priority: got %h expected 160630", dut_date());
        end
    endtask

    task automatic test_random();
        int m, y;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                y = (i % 120 == 0) ? 99 : int'($urandom_range(0, 99));
                m = int'($urandom_range(1, 12));
                set_date(maxd(m, y), m, y);
            end
            cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_month_ends();
        test_century();
        test_adjust_clamp();
        test_wraps_holds();
        test_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_date.md
Name: count_date

Overview:
- Day/month/year stage of the century clock, directly downstream of the hour counter.
- Advances a BCD calendar date (DD/MM/YY, years 00-99) by one day per hour-wrap pulse. In the top level, `en_d` is driven by the hour stage's `pulse_h`.
- Provides manual up/down adjustment of a selected field while not counting.
- Emits a one-cycle century pulse at the 31/12/99 -> 01/01/00 rollover.

Parameters:
- UNIT_W, 4, width of every BCD units digit.
- DAY_TEN_W, 2, width of the day tens digit (0-3).
- YEAR_TEN_W, 4, width of the year tens digit (0-9).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- en_d  input  1  one-day advance strobe (single-cycle, from hour stage).
- up  input  1  adjust increment request, level, one step per cycle.
- down  input  1  adjust decrement request, level, one step per cycle.
- sel  input  2  adjust field: 0 day, 1 month, 2 year, 3 none.
- day_unit  output  UNIT_W  day units BCD.
- day_ten  output  DAY_TEN_W  day tens BCD.
- month_unit  output  UNIT_W  month units BCD.
- month_ten  output  1  month tens BCD.
- year_unit  output  UNIT_W  year units BCD.
- year_ten  output  YEAR_TEN_W  year tens BCD.
- pulse_cen  output  1  century rollover strobe.

Behaviour:
- Clocking and reset:
  - One clock `clk`; `rst` is asynchronous, active-high.
  - Reset value: date 01/01/00; pulse_cen 0 (it is combinational from reset state).
- Leap rule:
  - Year YY is leap iff YY mod 4 == 0, i.e. year_ten even with unit in {0,4,8}, or year_ten odd with unit in {2,6}.
  - Year 00 is leap (2000).
- Days in month (maxd): 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; Feb 29 if leap, else 28.
- Count mode (en_d=1) has priority; up, down and sel are ignored. Next state:
  - day < maxd: day+1, with BCD carry at unit 9 (09->10, 19->20, 29->30).
  - day == maxd and month < 12: day=01, month+1 (09->10).
  - day == maxd and month == 12: day=01, month=01, year+1 (BCD); 99 -> 00.
- Adjust mode (en_d=0):
  - Exactly one of up/down asserted: step the selected field by one, BCD arithmetic.
  - up and down both asserted, neither asserted, or sel=3: hold.
  - Fields are independent in adjust mode; no carry into neighbouring fields.
  - Day: up at maxd -> 01; down at 01 -> maxd of the current month/year.
  - Month: 12 -> 01 up; 01 -> 12 down.
  - Year: 99 -> 00 up; 00 -> 99 down.
  - After a month or year step, day is clamped in the same update: day_next = min(day, maxd(month_next, year_next)). No invalid date is ever visible on the outputs.
- pulse_cen = en_d & (date == 31/12/99):
  - Combinational, high in the same cycle as the rollover edge, exactly one cycle per century.
  - Never asserted in adjust mode, including a year step 99 -> 00.
- Latency: all outputs except pulse_cen update on the clk edge following the stimulus cycle.
- rst asserted mid-operation: immediate return to 01/01/00; pulse_cen drops combinationally.
- Outputs never leave the legal BCD ranges: day 01..maxd, month 01..12, year 00..99.

Decomposition:
- Shared package clock_pkg holds:
  - SEL_DAY=2'd0, SEL_MONTH=2'd1, SEL_YEAR=2'd2, SEL_NONE=2'd3.
  - BCD limit constants (12, 99, 31, 30, 29, 28).
  - The leap-year decode function.
- One combinational sub-module, days_in_month:
  - Inputs: month BCD (ten, unit) and leap flag.
  - Output: maxd as BCD ten/unit.
  - Instantiated twice: once for the current date (counting, day wrap) and once for the next month/year (clamp).

Test Plan:
- Reset: assert rst for 3 cycles, release -> outputs 01/01/00, pulse_cen 0; rst mid-count forces 01/01/00 asynchronously.
- Month ends: from 28/02/23 en_d -> 01/03/23; from 28/02/24 en_d -> 29/02/24, en_d -> 01/03/24; from 30/04/24 en_d -> 01/05/24; 09/01/05 -> 10/01/05.
- Century: at 31/12/99 pulse en_d -> pulse_cen 1 that cycle only, next state 01/01/00. At 31/12/98 en_d -> 01/01/99, pulse_cen 0.
- Adjust and clamp: en_d=0, sel=1, up at 31/01/23 -> 28/02/23. sel=2, down at 29/02/24 -> 28/02/23. sel=0, down at 01/03/24 -> 31/03/24.
- Wraps and holds: sel=1 up at 12 -> 01, year unchanged. sel=2 down at 00 -> 99 with pulse_cen 0. up&down both -> hold. sel=3 with up -> hold.
- Priority: en_d=1 with sel=0, up=1 at 15/06/30 -> 16/06/30, a single step only.
